icache_refill_ctrl: RTL and testbench

ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

---
 rtl/icache_refill_ctrl_if.sv | 44 ++++
 rtl/icache_refill_ctrl.sv | 119 +++++++++++
 tb/tb_icache_refill_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/icache_refill_ctrl_if.sv
// I$ refill bundle: miss request, memory read channel and line-buffer fill port.
// Latency: none (wires only).
// Backpressure: the memory side stalls the controller by withholding mem_gnt_i.
// Ports: master = refill controller, slave = cache/memory environment.
interface icache_refill_ctrl_if #(
    parameter int LINE_WORDS = 8
);
    localparam int IDX_W = $clog2(LINE_WORDS);

    // Miss request from the fetch unit
    logic             miss_i;
    logic [31:0]      miss_paddr_i;
    logic             block_refill_i;
    logic             flush_i;
    // Memory read channel
    logic             mem_req_o;
    logic [31:0]      mem_addr_o;
    logic             mem_gnt_i;
    logic             mem_rvalid_i;
    logic [31:0]      mem_rdata_i;
    logic             mem_err_i;
    // Line-buffer fill and status
    logic             fill_we_o;
    logic [IDX_W-1:0] fill_idx_o;
    logic [31:0]      fill_data_o;
    logic             fill_done_o;
    logic             refill_err_o;
    logic [31:0]      refill_err_tval_o;
    logic             busy_o;

    modport master (
        input  miss_i, miss_paddr_i, block_refill_i, flush_i,
               mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
        output mem_req_o, mem_addr_o, fill_we_o, fill_idx_o, fill_data_o,
               fill_done_o, refill_err_o, refill_err_tval_o, busy_o
    );

    modport slave (
        output miss_i, miss_paddr_i, block_refill_i, flush_i,
               mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
        input  mem_req_o, mem_addr_o, fill_we_o, fill_idx_o, fill_data_o,
               fill_done_o, refill_err_o, refill_err_tval_o, busy_o
    );
endinterface

// File: rtl/icache_refill_ctrl.sv
// I$ line refill controller: critical-word-first, one outstanding read at a time.
// Latency: first request one cycle after miss is accepted; fill writes same cycle as rvalid.
// Backpressure: holds mem_req_o/mem_addr_o until mem_gnt_i; waits indefinitely for rvalid.
// Ports: clk, rst_n (async active-low), bus (master modport of icache_refill_ctrl_if).
// LINE_WORDS must be a power of two in 2..16.
module icache_refill_ctrl #(
    parameter int LINE_WORDS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    icache_refill_ctrl_if.master  bus
);
    localparam int IDX_W  = $clog2(LINE_WORDS);
    localparam int BASE_W = 30 - IDX_W;   // line-address bits above index and byte offset

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [BASE_W-1:0] base_q, base_d;
    logic [IDX_W-1:0]  start_q, start_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       tval_q, tval_d;

    logic [IDX_W-1:0]  cur_idx;
    logic [31:0]       beat_addr;
    logic              last_beat;
    logic              req;
    logic              we;
    logic              done;
    logic              err;

    // Index arithmetic is IDX_W wide, so start+count wraps inside the line for free.
    assign cur_idx   = start_q + cnt_q;
    assign beat_addr = {base_q, cur_idx, 2'b00};
    assign last_beat = (cnt_q == IDX_W'(LINE_WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            start_q <= '0;
            cnt_q   <= '0;
            tval_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            start_q <= start_d;
            cnt_q   <= cnt_d;
            tval_q  <= tval_d;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        start_d = start_q;
        cnt_d   = cnt_q;
        tval_d  = tval_q;
        req     = 1'b0;
        we      = 1'b0;
        done    = 1'b0;
        err     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.miss_i && !bus.block_refill_i && !bus.flush_i) begin
                    state_d = REQ;
                    base_d  = bus.miss_paddr_i[31:IDX_W+2];
                    start_d = bus.miss_paddr_i[IDX_W+1:2];
                    cnt_d   = '0;
                end
            end
            REQ: begin
                req = 1'b1;
                if (bus.flush_i) begin
                    // A granted request still owes a response that must be swallowed.
                    state_d = bus.mem_gnt_i ? DRAIN : IDLE;
                end else if (bus.mem_gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.flush_i) begin
                    if (bus.mem_rvalid_i) state_d = IDLE;
                    else                  state_d = DRAIN;
                end else if (bus.mem_rvalid_i) begin
                    if (bus.mem_err_i) begin
                        err     = 1'b1;
                        tval_d  = beat_addr;
                        state_d = IDLE;
                    end else begin
                        we = 1'b1;
                        if (last_beat) begin
                            done    = 1'b1;
                            state_d = IDLE;
                        end else begin
                            cnt_d   = cnt_q + 1'b1;
                            state_d = REQ;
                        end
                    end
                end
            end
            DRAIN: begin
                if (bus.mem_rvalid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_req_o         = req;
    assign bus.mem_addr_o        = (state_q == REQ) ? beat_addr : 32'h0;
    assign bus.fill_we_o         = we;
    assign bus.fill_idx_o        = (state_q == WAIT) ? cur_idx : '0;
    assign bus.fill_data_o       = bus.mem_rdata_i;
    assign bus.fill_done_o       = done;
    assign bus.refill_err_o      = err;
    assign bus.refill_err_tval_o = tval_q;
    assign bus.busy_o            = (state_q != IDLE);
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl (LINE_WORDS=8): per-cycle vector table plus reset sequence.
module tb_icache_refill_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    icache_refill_ctrl_if #(.LINE_WORDS(8)) bus ();
    icache_refill_ctrl #(.LINE_WORDS(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic        miss;
        logic [31:0] paddr;
        logic        blk;
        logic        flush;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        err;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_we;
        logic [2:0]  e_idx;
        logic        e_done;
        logic        e_rerr;
        logic        e_busy;
        logic [31:0] e_tval;
    } vec_t;

    vec_t vecs[$];
    int total = 0;
    int bad   = 0;

    task automatic add(input logic miss, input logic [31:0] paddr, input logic blk,
                       input logic flush, input logic gnt, input logic rv,
                       input logic [31:0] rdata, input logic err,
                       input logic e_req, input logic [31:0] e_addr, input logic e_we,
                       input logic [2:0] e_idx, input logic e_done, input logic e_rerr,
                       input logic e_busy, input logic [31:0] e_tval);
        vec_t v;
        v.miss = miss; v.paddr = paddr; v.blk = blk; v.flush = flush; v.gnt = gnt;
        v.rv = rv; v.rdata = rdata; v.err = err;
        v.e_req = e_req; v.e_addr = e_addr; v.e_we = e_we; v.e_idx = e_idx;
        v.e_done = e_done; v.e_rerr = e_rerr; v.e_busy = e_busy; v.e_tval = e_tval;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step%0d: got %h want %h", nm, n, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.miss_i         = v.miss;
        bus.miss_paddr_i   = v.paddr;
        bus.block_refill_i = v.blk;
        bus.flush_i        = v.flush;
        bus.mem_gnt_i      = v.gnt;
        bus.mem_rvalid_i   = v.rv;
        bus.mem_rdata_i    = v.rdata;
        bus.mem_err_i      = v.err;
    endtask

    task automatic chk_quiet(input string nm, input int n);
        chk({nm, "_req"},  n, 32'(bus.mem_req_o), 32'h0);
        chk({nm, "_we"},   n, 32'(bus.fill_we_o), 32'h0);
        chk({nm, "_done"}, n, 32'(bus.fill_done_o), 32'h0);
        chk({nm, "_rerr"}, n, 32'(bus.refill_err_o), 32'h0);
        chk({nm, "_busy"}, n, 32'(bus.busy_o), 32'h0);
    endtask

    logic [31:0] a29 [8] = '{32'h1014, 32'h1018, 32'h101C, 32'h1000,
                             32'h1004, 32'h1008, 32'h100C, 32'h1010};
    logic [2:0]  i29 [8] = '{3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};

    initial begin
        vec_t z;
        z = '{default: '0};
        drive(z);
        repeat (2) @(negedge clk);
        #1;
        // Reset state while rst_n is still low
        chk_quiet("rst", 0);
        chk("rst_addr", 0, bus.mem_addr_o, 32'h0);
        chk("rst_idx",  0, 32'(bus.fill_idx_o), 32'h0);
        chk("rst_tval", 0, bus.refill_err_tval_o, 32'h0);
        rst_n = 1'b1;

        // ---- vector table ----
        add(0,0,0,0,0,0,0,0,             0,0,0,0,0,0,0,0);
        // critical-word-first line at 0x1014
        add(1,32'h1014,0,0,0,0,0,0,      0,0,0,0,0,0,0,0);
        for (int n = 0; n < 8; n++) begin
            add(1,32'h1014,0,0,1,0,0,0,  1,a29[n],0,0,0,0,1,0);
            add(1,32'h1014,0,0,0,1,32'hA500_0000+n,0, 0,0,1,i29[n],(n==7),0,1,0);
        end
        add(0,0,0,0,0,0,0,0,             0,0,0,0,0,0,0,0);
        // blocked miss, then release
        for (int n = 0; n < 10; n++)
            add(1,32'h4000,1,0,0,0,0,0,  0,0,0,0,0,0,0,0);
        add(1,32'h4000,0,0,0,0,0,0,      0,0,0,0,0,0,0,0);
        // grant withheld 5 cycles: request and address must hold
        for (int n = 0; n < 5; n++)
            add(1,32'h4000,0,0,0,0,0,0,  1,32'h4000,0,0,0,0,1,0);
        add(1,32'h4000,0,0,1,0,0,0,      1,32'h4000,0,0,0,0,1,0);
        // flush in WAIT, response 4 cycles later lands in DRAIN
        add(0,0,0,1,0,0,0,0,             0,0,0,0,0,0,1,0);
        for (int n = 0; n < 3; n++)
            add(0,0,0,0,0,0,0,0,         0,0,0,0,0,0,1,0);
        add(0,0,0,0,0,1,32'hDEAD_BEEF,0, 0,0,0,0,0,0,1,0);
        add(0,0,0,0,0,0,0,0,             0,0,0,0,0,0,0,0);
        // clean restart at 0x3008, then flush in REQ without grant
        add(1,32'h3008,0,0,0,0,0,0,      0,0,0,0,0,0,0,0);
        add(1,32'h3008,0,0,1,0,0,0,      1,32'h3008,0,0,0,0,1,0);
        add(1,32'h3008,0,0,0,1,32'h3333_0001,0, 0,0,1,3'd2,0,0,1,0);
        add(0,0,0,1,0,0,0,0,             1,32'h300C,0,0,0,0,1,0);
        add(0,0,0,0,0,0,0,0,             0,0,0,0,0,0,0,0);
        // flush with grant -> DRAIN; errored response swallowed
        add(1,32'h5000,0,0,0,0,0,0,      0,0,0,0,0,0,0,0);
        add(0,0,0,1,1,0,0,0,             1,32'h5000,0,0,0,0,1,0);
        add(0,0,0,0,0,1,32'h5,1,         0,0,0,0,0,0,1,0);
        add(0,0,0,0,0,0,0,0,             0,0,0,0,0,0,0,0);
        // flush in WAIT together with rvalid -> straight to IDLE
        add(1,32'h6000,0,0,0,0,0,0,      0,0,0,0,0,0,0,0);
        add(1,32'h6000,0,0,1,0,0,0,      1,32'h6000,0,0,0,0,1,0);
        add(0,0,0,1,0,1,32'h66,0,        0,0,0,0,0,0,1,0);
        add(0,0,0,0,0,0,0,0,             0,0,0,0,0,0,0,0);
        // bus error on third beat of line 0x2000
        add(1,32'h2000,0,0,0,0,0,0,      0,0,0,0,0,0,0,0);
        add(1,32'h2000,0,0,1,0,0,0,      1,32'h2000,0,0,0,0,1,0);
        add(1,32'h2000,0,0,0,1,32'h2222_0000,0, 0,0,1,3'd0,0,0,1,0);
        add(1,32'h2000,0,0,1,0,0,0,      1,32'h2004,0,0,0,0,1,0);
        add(1,32'h2000,0,0,0,1,32'h2222_0001,0, 0,0,1,3'd1,0,0,1,0);
        add(1,32'h2000,0,0,1,0,0,0,      1,32'h2008,0,0,0,0,1,0);
        add(1,32'h2000,0,0,0,1,32'h0BAD,1, 0,0,0,0,0,1,1,0);
        // miss still high: one IDLE dwell cycle before the retry
        add(1,32'h2000,0,0,0,0,0,0,      0,0,0,0,0,0,0,32'h2008);
        add(1,32'h2000,0,0,1,0,0,0,      1,32'h2000,0,0,0,0,1,32'h2008);
        add(1,32'h2000,0,0,0,1,32'h7777,0, 0,0,1,3'd0,0,0,1,32'h2008);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #2;
            chk("req",  i, 32'(bus.mem_req_o),    32'(vecs[i].e_req));
            chk("busy", i, 32'(bus.busy_o),       32'(vecs[i].e_busy));
            chk("we",   i, 32'(bus.fill_we_o),    32'(vecs[i].e_we));
            chk("done", i, 32'(bus.fill_done_o),  32'(vecs[i].e_done));
            chk("rerr", i, 32'(bus.refill_err_o), 32'(vecs[i].e_rerr));
            chk("tval", i, bus.refill_err_tval_o, vecs[i].e_tval);
            if (vecs[i].e_req)
                chk("addr", i, bus.mem_addr_o, vecs[i].e_addr);
            if (vecs[i].e_we) begin
                chk("idx",  i, 32'(bus.fill_idx_o), 32'(vecs[i].e_idx));
                chk("data", i, bus.fill_data_o, vecs[i].rdata);
            end
        end

        // ---- reset pulsed mid-line (controller now requesting beat at 0x2004) ----
        @(negedge clk);
        z.miss = 1'b1; z.paddr = 32'h2000;
        drive(z);
        #1;
        chk("pre_rst_addr", 900, bus.mem_addr_o, 32'h2004);
        rst_n = 1'b0;
        #1;
        chk_quiet("mid_rst", 901);
        chk("mid_rst_addr", 901, bus.mem_addr_o, 32'h0);
        chk("mid_rst_idx",  901, 32'(bus.fill_idx_o), 32'h0);
        chk("mid_rst_tval", 901, bus.refill_err_tval_o, 32'h0);
        @(negedge clk);
        // Late response to the abandoned request must not produce pulses.
        z.miss = 1'b0; z.paddr = 32'h0; z.rv = 1'b1; z.rdata = 32'h1234;
        drive(z);
        rst_n = 1'b1;
        #2;
        chk_quiet("post_rst0", 902);
        @(negedge clk);
        z.rv = 1'b0;
        drive(z);
        #2;
        chk_quiet("post_rst1", 903);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
